mux_stream_nin1: RTL and testbench
==================================

# mux_stream_nin1

Parametrised N-input, WIDTH-bit stream multiplexer with a registered output and valid/ready handshakes on every channel. It runs in one of two modes: fixed select, where an external select picks the channel, or round-robin arbitration across all valid channels. It sits between several producer streams and a single consumer. It is the sequential successor to the 5-to-1 combinational data mux.

## Interface

Parameters:
- WIDTH, 8, data width per channel
- N, 5, number of input channels (2..16)
- SEL_W, $clog2(N), width of the select and channel-ID fields

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_mode  in  1  0 = fixed select, 1 = round-robin
- i_sel  in  SEL_W  channel index, used only in fixed mode
- i_dat  in  N*WIDTH  packed input data; channel k is at [k*WIDTH +: WIDTH]
- i_vld  in  N  per-channel valid
- o_rdy  out  N  per-channel ready, combinational; one-hot or zero
- o_dat  out  WIDTH  registered output data
- o_vld  out  1  registered output valid
- o_ch  out  SEL_W  index of the channel that supplied o_dat
- i_rdy  in  1  downstream ready

## Operation

- Output stage: a single register slot holding o_dat, o_vld and o_ch.
  - Slot can load when accept = !o_vld || i_rdy.
  - A downstream transfer happens when o_vld && i_rdy.
- Grant logic (combinational) produces grant_vld and grant_ch.
  - Fixed mode: grant_ch = i_sel; grant_vld = (i_sel < N) && i_vld[i_sel].
  - If i_sel >= N, no channel is ever granted and all o_rdy bits are 0.
- Round-robin mode:
  - Internal pointer ptr (SEL_W bits) holds the last channel granted.
  - Search order is ptr+1, ptr+2, …, wrapping from N-1 to 0, ending at ptr itself.
  - The first channel with i_vld set is granted.
  - grant_vld = |i_vld.
- o_rdy[k] = accept && grant_vld && (grant_ch == k).
- Upstream transfer on channel k (i_vld[k] && o_rdy[k]) loads o_dat ← channel k data, o_ch ← k, o_vld ← 1.
  - In round-robin mode it also sets ptr ← k.
  - In fixed mode ptr is not updated.
- If accept is high but there is no grant: o_vld ← 0; o_dat and o_ch hold their last values.
- If accept is low: the output register holds; o_dat must stay stable while o_vld && !i_rdy.
- A change on i_mode or i_sel takes effect at the next grant evaluation. An item already in the slot is never dropped or altered.
- A channel may deassert i_vld without a transfer; the grant simply moves on.

## Timing

- Reset (i_rst high at an edge) sets o_vld=0, o_dat=0, o_ch=0 and ptr=N-1, so channel 0 has first round-robin priority.
  - o_rdy is all-zero for the duration of reset.
  - Reset overrides any simultaneous transfer.
  - An item held in the slot is discarded.
- Latency: one cycle from the upstream transfer edge to o_vld/o_dat/o_ch valid.
- Throughput: one item per cycle while i_rdy stays high. Loading and draining in the same cycle is allowed; this is the accept path through i_rdy.
- o_rdy depends combinationally on i_vld, i_sel, i_mode, o_vld and i_rdy. It has no path from o_rdy back to itself.
- Round-robin fairness: with every channel continuously valid and i_rdy=1, each channel gets exactly one grant in any N consecutive transfers.
- Back-pressure: while i_rdy=0 and o_vld=1, all o_rdy bits are 0 and ptr holds.

## Test plan

- **Fixed mode, valid/ready:** N=5, WIDTH=8, i_mode=0, i_rdy=1, all i_vld=1, random data, i_sel stepping 0..7 with 10 items each.
  - For sel 0..4: o_dat equals the sampled i_dat of that channel one cycle later, and o_ch=sel.
  - For sel 5..7: o_vld=0 and o_rdy=0 throughout.
- **Round-robin, all valid:** i_mode=1, all i_vld=1, i_rdy=1, after reset.
  - o_ch sequence is 0,1,2,3,4,0,1…
  - Exactly one o_rdy bit is high per cycle.
- **Sparse round-robin:** only i_vld[1] and i_vld[3] set. o_ch alternates 1,3,1,3.
  - Then raise i_vld[2] after a grant to 1: the next grant is 2, followed by 3.
- **Back-pressure:** hold i_rdy=0 for 4 cycles with o_vld=1 and o_dat=0xA5.
  - o_dat stays 0xA5, o_ch is stable and o_rdy=0.
  - After i_rdy rises, the next item follows with no loss or duplication; a scoreboard compares per-channel order.
- **Reset mid-stream:** assert i_rst while o_vld=1 and i_rdy=0.
  - Next cycle: o_vld=0, o_dat=0, o_ch=0.
  - The first round-robin grant after release goes to channel 0.
- **Mode switch:** in round-robin mode, grant channel 2, then switch to fixed mode with i_sel=4.
  - The next grant is 4 and ptr stays 2.
  - Switch back to round-robin: the next grant is 3.

Source files
------------

// File: rtl/mux_stream_nin1.sv
// N-input stream multiplexer with a single registered output slot.
// Channel choice is either an external select (fixed mode) or a round-robin
// search starting just after the last granted channel.
module mux_stream_nin1 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 5,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mode,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [N*WIDTH-1:0] i_dat,
  input  logic [N-1:0]       i_vld,
  output logic [N-1:0]       o_rdy,
  output logic [WIDTH-1:0]   o_dat,
  output logic               o_vld,
  output logic [SEL_W-1:0]   o_ch,
  input  logic               i_rdy
);

  // Output slot and round-robin pointer (last channel granted).
  logic [WIDTH-1:0] r_dat;
  logic             r_vld;
  logic [SEL_W-1:0] r_ch;
  logic [SEL_W-1:0] r_ptr;

  logic             w_accept;
  logic             w_fix_vld;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_rr_ch;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant_ch;
  logic [WIDTH-1:0] w_grant_dat;
  int unsigned      w_idx;

  // Slot can take a new item when empty or when it is draining this cycle.
  assign w_accept = !r_vld || i_rdy;

  // Fixed mode: only an in-range select can ever produce a grant.
  always_comb begin
    w_fix_vld = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_fix_vld = i_vld[k];
      end
    end
  end

  // Round-robin: first valid channel in order ptr+1, ptr+2, ..., ptr.
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_ch  = '0;
    w_idx    = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = (32'(r_ptr) + i) % N;
      for (int unsigned k = 0; k < N; k++) begin
        if (!w_rr_vld && (w_idx == k) && i_vld[k]) begin
          w_rr_vld = 1'b1;
          w_rr_ch  = SEL_W'(k);
        end
      end
    end
  end

  assign w_grant_vld = i_mode ? w_rr_vld : w_fix_vld;
  assign w_grant_ch  = i_mode ? w_rr_ch  : i_sel;

  // Decode the grant into a one-hot ready and pick the granted data.
  always_comb begin
    o_rdy       = '0;
    w_grant_dat = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_grant_ch == SEL_W'(k)) begin
        w_grant_dat = i_dat[k*WIDTH +: WIDTH];
        // Ready is held low while reset is asserted.
        o_rdy[k]    = w_accept && w_grant_vld && !i_rst;
      end
    end
  end

  // Output slot update; pointer only advances on round-robin transfers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_ch  <= '0;
      r_ptr <= SEL_W'(N - 1);
    end else if (w_accept) begin
      r_vld <= w_grant_vld;
      if (w_grant_vld) begin
        r_dat <= w_grant_dat;
        r_ch  <= w_grant_ch;
        if (i_mode) begin
          r_ptr <= w_grant_ch;
        end
      end
    end
  end

  assign o_dat = r_dat;
  assign o_vld = r_vld;
  assign o_ch  = r_ch;

endmodule

// File: tb/tb_mux_stream_nin1.sv
// Bench for mux_stream_nin1: table vectors, directed sequences and random
// traffic compared against a transaction-level model of the mux.
module tb_mux_stream_nin1;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 5;
  localparam int unsigned SEL_W = 3;

  logic               i_clk;
  logic               i_rst;
  logic               i_mode;
  logic [SEL_W-1:0]   i_sel;
  logic [N*WIDTH-1:0] i_dat;
  logic [N-1:0]       i_vld;
  logic [N-1:0]       o_rdy;
  logic [WIDTH-1:0]   o_dat;
  logic               o_vld;
  logic [SEL_W-1:0]   o_ch;
  logic               i_rdy;

  mux_stream_nin1 #(
    .WIDTH(WIDTH),
    .N    (N),
    .SEL_W(SEL_W)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_mode(i_mode),
    .i_sel (i_sel),
    .i_dat (i_dat),
    .i_vld (i_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_vld (o_vld),
    .o_ch  (o_ch),
    .i_rdy (i_rdy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks;
  int n_fail;

  // Model of the output slot and the last round-robin winner.
  bit             m_known;
  bit             m_vld;
  logic [7:0]     m_dat;
  int             m_ch;
  int             m_ptr;

  typedef struct packed {
    logic       mode;
    logic [2:0] sel;
    logic [4:0] vld;
    logic       rdy;
    logic [4:0] e_rdy;
    logic       e_vld;
    logic [2:0] e_ch;
  } vec_t;

  vec_t vecs[10];
  int   exp_sp[5];
  logic [N*WIDTH-1:0] cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant straight from the rules: fixed picks i_sel if in range and valid;
  // round-robin scans ptr+1 .. ptr+N modulo N for the first valid channel.
  function automatic void m_grant(output bit gv, output int gc);
    gv = 1'b0;
    gc = 0;
    if (!i_mode) begin
      for (int k = 0; k < N; k++) begin
        if (k == int'(i_sel) && i_vld[k]) begin
          gv = 1'b1;
          gc = k;
        end
      end
    end else begin
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (m_ptr + off) % N;
        if (!gv && i_vld[c]) begin
          gv = 1'b1;
          gc = c;
        end
      end
    end
  endfunction

  task automatic settle_check();
    bit         gv;
    int         gc;
    bit         acc;
    logic [4:0] e;
    #1;
    if (m_known) begin
      m_grant(gv, gc);
      acc = !m_vld || i_rdy;
      e   = (!i_rst && acc && gv) ? (5'b00001 << gc) : 5'b00000;
      chk("model_rdy", o_rdy, e);
      chk("model_vld", o_vld, m_vld);
      chk("model_dat", o_dat, m_dat);
      chk("model_ch", o_ch, m_ch);
    end
  endtask

  task automatic clk_edge();
    bit gv;
    int gc;
    @(posedge i_clk);
    m_grant(gv, gc);
    if (i_rst) begin
      m_known = 1'b1;
      m_vld   = 1'b0;
      m_dat   = 8'h00;
      m_ch    = 0;
      m_ptr   = N - 1;
    end else if (!m_vld || i_rdy) begin
      if (gv) begin
        m_vld = 1'b1;
        m_dat = i_dat[gc*WIDTH +: WIDTH];
        m_ch  = gc;
        if (i_mode) m_ptr = gc;
      end else begin
        m_vld = 1'b0;
      end
    end
    #1;
  endtask

  task automatic tick();
    settle_check();
    clk_edge();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic rand_dat();
    i_dat = 40'({$urandom(), $urandom()});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_known  = 1'b0;
    m_vld    = 1'b0;
    m_dat    = 8'h00;
    m_ch     = 0;
    m_ptr    = N - 1;
    i_rst    = 1'b1;
    i_mode   = 1'b0;
    i_sel    = '0;
    i_dat    = '0;
    i_vld    = '0;
    i_rdy    = 1'b0;

    //            mode sel    vld       rdy  e_rdy     e_vld e_ch
    vecs[0] = '{1'b0, 3'd0, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
    vecs[1] = '{1'b0, 3'd3, 5'b01000, 1'b1, 5'b01000, 1'b1, 3'd3};
    vecs[2] = '{1'b0, 3'd3, 5'b10111, 1'b1, 5'b00000, 1'b0, 3'd0};
    vecs[3] = '{1'b0, 3'd5, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd0};
    vecs[4] = '{1'b0, 3'd7, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd0};
    vecs[5] = '{1'b1, 3'd6, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
    vecs[6] = '{1'b1, 3'd0, 5'b11110, 1'b1, 5'b00010, 1'b1, 3'd1};
    vecs[7] = '{1'b1, 3'd2, 5'b10000, 1'b0, 5'b10000, 1'b1, 3'd4};
    vecs[8] = '{1'b1, 3'd1, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0};
    vecs[9] = '{1'b0, 3'd4, 5'b10000, 1'b0, 5'b10000, 1'b1, 3'd4};
    exp_sp  = '{1, 3, 1, 2, 3};

    clk_edge();
    do_reset();

    // Reset state.
    settle_check();
    chk("reset_vld", o_vld, 0);
    chk("reset_dat", o_dat, 0);
    chk("reset_ch", o_ch, 0);

    // Table vectors, each from a freshly reset slot.
    for (int t = 0; t < 10; t++) begin
      do_reset();
      for (int k = 0; k < N; k++) i_dat[k*WIDTH +: WIDTH] = 8'h10 + 8'(k);
      i_mode = vecs[t].mode;
      i_sel  = vecs[t].sel;
      i_vld  = vecs[t].vld;
      i_rdy  = vecs[t].rdy;
      settle_check();
      chk("tbl_rdy", o_rdy, vecs[t].e_rdy);
      clk_edge();
      chk("tbl_vld", o_vld, vecs[t].e_vld);
      chk("tbl_ch", o_ch, vecs[t].e_ch);
      chk("tbl_dat", o_dat, vecs[t].e_vld ? 8'h10 + 8'(vecs[t].e_ch) : 8'h00);
    end

    // Fixed mode, select stepping through in-range and out-of-range values.
    do_reset();
    i_mode = 1'b0;
    i_rdy  = 1'b1;
    i_vld  = '1;
    for (int s = 0; s < 8; s++) begin
      i_sel = SEL_W'(s);
      for (int it = 0; it < 10; it++) begin
        rand_dat();
        cap = i_dat;
        settle_check();
        if (s >= N) chk("fix_rdy_oob", o_rdy, 0);
        clk_edge();
        if (s < N) begin
          chk("fix_dat", o_dat, cap[s*WIDTH +: WIDTH]);
          chk("fix_ch", o_ch, s);
        end else begin
          chk("fix_vld_oob", o_vld, 0);
        end
      end
    end

    // Round-robin with every channel valid.
    do_reset();
    i_mode = 1'b1;
    i_vld  = '1;
    i_rdy  = 1'b1;
    for (int j = 0; j < 10; j++) begin
      rand_dat();
      settle_check();
      chk("rr_onehot", $countones(o_rdy), 1);
      clk_edge();
      chk("rr_seq", o_ch, j % N);
    end

    // Sparse round-robin, then channel 2 joins after a grant to 1.
    do_reset();
    i_vld = 5'b01010;
    for (int j = 0; j < 5; j++) begin
      if (j == 3) i_vld = 5'b01110;
      rand_dat();
      tick();
      chk("sparse_seq", o_ch, exp_sp[j]);
    end

    // Back-pressure on a held 0xA5 item.
    do_reset();
    i_mode = 1'b0;
    i_sel  = 3'd2;
    i_vld  = '1;
    i_rdy  = 1'b1;
    rand_dat();
    i_dat[2*WIDTH +: WIDTH] = 8'hA5;
    tick();
    chk("bp_load", o_dat, 8'hA5);
    i_rdy = 1'b0;
    for (int j = 0; j < 4; j++) begin
      rand_dat();
      settle_check();
      chk("bp_rdy", o_rdy, 0);
      clk_edge();
      chk("bp_dat", o_dat, 8'hA5);
      chk("bp_ch", o_ch, 2);
      chk("bp_vld", o_vld, 1);
    end
    i_rdy = 1'b1;
    rand_dat();
    cap = i_dat;
    tick();
    chk("bp_next", o_dat, cap[2*WIDTH +: WIDTH]);

    // Reset while the slot holds an item under back-pressure.
    i_rdy = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
    chk("rst_mid_vld", o_vld, 0);
    chk("rst_mid_dat", o_dat, 0);
    chk("rst_mid_ch", o_ch, 0);
    i_rst  = 1'b0;
    i_mode = 1'b1;
    i_rdy  = 1'b1;
    i_vld  = '1;
    tick();
    chk("rst_first_rr", o_ch, 0);

    // Mode switch: fixed-mode grants leave the round-robin pointer alone.
    do_reset();
    i_mode = 1'b1;
    i_vld  = 5'b00100;
    tick();
    chk("sw_rr2", o_ch, 2);
    i_mode = 1'b0;
    i_sel  = 3'd4;
    i_vld  = '1;
    tick();
    chk("sw_fix4", o_ch, 4);
    i_mode = 1'b1;
    tick();
    chk("sw_rr3", o_ch, 3);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      i_rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) i_mode = ~i_mode;
      i_sel = SEL_W'($urandom_range(0, 7));
      i_vld = N'($urandom());
      i_rdy = ($urandom_range(0, 3) != 0);
      rand_dat();
      tick();
    end
    i_rst = 1'b0;
    settle_check();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
